// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file and its scoreboard.
// Optional build macro used by the importing files: REGFILE_WB_BYPASS_EN.
package regfile_pkg;

  localparam int          RF_DATA_W   = 32;
  localparam int          RF_ADDR_W   = 4;
  localparam int          RF_SP_IDX   = 14;
  localparam logic [31:0] RF_SP_RESET = 32'h0000_1000;

  typedef enum logic {
    WP_ALU = 1'b0,
    WP_LD  = 1'b1
  } wport_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears, set wins on collision.
// REGFILE_WB_BYPASS_EN: rd_busy also sees a same-cycle clearing write.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     iss_en_i,
  input  logic [ADDR_W-1:0]        iss_addr_i,
  input  logic                     w0_en_i,
  input  logic [ADDR_W-1:0]        w0_addr_i,
  input  logic                     w1_en_i,
  input  logic [ADDR_W-1:0]        w1_addr_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD-1:0]        rd_busy_o
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [NREGS-1:0] busy_q, busy_d;

  // Clears first, then the issue set, so a new producer keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (w0_en_i)  busy_d[w0_addr_i]  = 1'b0;
    if (w1_en_i)  busy_d[w1_addr_i]  = 1'b0;
    if (iss_en_i) busy_d[iss_addr_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    ra        = '0;
    rd_busy_o = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      ra           = rd_addr_i[p*ADDR_W +: ADDR_W];
      rd_busy_o[p] = busy_q[ra];
`ifdef REGFILE_WB_BYPASS_EN
      if (((w0_en_i && (w0_addr_i == ra)) || (w1_en_i && (w1_addr_i == ra))) &&
          !(iss_en_i && (iss_addr_i == ra)))
        rd_busy_o[p] = 1'b0;
`endif
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file: NUM_RD registered read ports, ALU (w0) and load (w1) write ports.
// REGFILE_WB_BYPASS_EN selects write-first reads; default build is read-first.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int                DATA_W   = RF_DATA_W,
  parameter int                ADDR_W   = RF_ADDR_W,
  parameter int                NUM_RD   = 2,
  parameter int                SP_IDX   = RF_SP_IDX,
  parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(RF_SP_RESET)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     w0_en,
  input  logic [ADDR_W-1:0]        w0_addr,
  input  logic [DATA_W-1:0]        w0_data,
  input  logic                     w1_en,
  input  logic [ADDR_W-1:0]        w1_addr,
  input  logic [DATA_W-1:0]        w1_data,
  output logic                     wr_conflict
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]        regs_q [NREGS];
  logic [DATA_W-1:0]        regs_d [NREGS];
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic                     wr_conflict_q, wr_conflict_d;

  function automatic logic wr_hit(input logic [ADDR_W-1:0] a);
    return (w0_en && (w0_addr == a)) || (w1_en && (w1_addr == a));
  endfunction

  // The load port wins whenever it targets the address.
  function automatic wport_e wr_src(input logic [ADDR_W-1:0] a);
    return (w1_en && (w1_addr == a)) ? WP_LD : WP_ALU;
  endfunction

  function automatic logic [DATA_W-1:0] wr_mux(input wport_e sel);
    return (sel == WP_LD) ? w1_data : w0_data;
  endfunction

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NREGS; i++) begin
      if (wr_hit(ADDR_W'(i))) regs_d[i] = wr_mux(wr_src(ADDR_W'(i)));
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    ra        = '0;
    rd_data_d = rd_data_q;
    for (int p = 0; p < NUM_RD; p++) begin
      if (rd_en[p]) begin
        ra = rd_addr[p*ADDR_W +: ADDR_W];
`ifdef REGFILE_WB_BYPASS_EN
        rd_data_d[p*DATA_W +: DATA_W] = wr_hit(ra) ? wr_mux(wr_src(ra)) : regs_q[ra];
`else
        rd_data_d[p*DATA_W +: DATA_W] = regs_q[ra];
`endif
      end
    end
  end

  assign wr_conflict_d = w0_en && w1_en && (w0_addr == w1_addr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end
      rd_data_q     <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      rd_data_q     <= rd_data_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign wr_conflict = wr_conflict_q;

  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_sb (
    .clk        (clk),
    .reset_n    (reset_n),
    .iss_en_i   (iss_en),
    .iss_addr_i (iss_addr),
    .w0_en_i    (w0_en),
    .w0_addr_i  (w0_addr),
    .w1_en_i    (w1_en),
    .w1_addr_i  (w1_addr),
    .rd_addr_i  (rd_addr),
    .rd_busy_o  (rd_busy)
  );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed self-checking bench for regfile_mp_sb (default parameters, two read ports).
// Expectations follow REGFILE_WB_BYPASS_EN when the build defines it.
module tb_regfile_mp_sb;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NR-1:0]     rd_en;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic              w0_en;
  logic [AW-1:0]     w0_addr;
  logic [DW-1:0]     w0_data;
  logic              w1_en;
  logic [AW-1:0]     w1_addr;
  logic [DW-1:0]     w1_data;
  logic              wr_conflict;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_mp_sb dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .iss_en      (iss_en),
    .iss_addr    (iss_addr),
    .w0_en       (w0_en),
    .w0_addr     (w0_addr),
    .w0_data     (w0_data),
    .w1_en       (w1_en),
    .w1_addr     (w1_addr),
    .w1_data     (w1_data),
    .wr_conflict (wr_conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = '0; iss_en = 1'b0; w0_en = 1'b0; w1_en = 1'b0;
  endtask

  task automatic set_rd(input logic [NR-1:0] en, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_en   = en;
    rd_addr = {a1, a0};
  endtask

  function automatic logic [DW-1:0] port(input int p);
    return rd_data[p*DW +: DW];
  endfunction

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    idle();
    rd_addr  = '0;
    iss_addr = '0;
    w0_addr  = '0; w0_data = '0;
    w1_addr  = '0; w1_data = '0;

    // Reset state
    tick();
    tick();
    check("rst_rd0", port(0), 32'h0);
    check("rst_rd1", port(1), 32'h0);
    check("rst_conflict", {31'b0, wr_conflict}, 32'h0);
    reset_n = 1'b1;
    tick();

    // 1: every register after reset
    for (int i = 0; i < 16; i += 2) begin
      set_rd(2'b11, AW'(i), AW'(i + 1));
      tick();
      check($sformatf("init_r%0d", i),     port(0), (i == 14) ? 32'h1000 : 32'h0);
      check($sformatf("init_r%0d", i + 1), port(1), 32'h0);
      check($sformatf("init_busy%0d", i),  {30'b0, rd_busy}, 32'h0);
    end
    idle();

    // 2: write then read with one-cycle latency; disabled port holds
    w0_en = 1'b1; w0_addr = 4'd3; w0_data = 32'hDEADBEEF;
    tick();
    idle();
    set_rd(2'b01, 4'd3, 4'd0);
    tick();
    check("wr_rd_r3", port(0), 32'hDEADBEEF);
    check("hold_p1", port(1), 32'h0);
    set_rd(2'b00, 4'd14, 4'd14);
    tick();
    check("hold_p0", port(0), 32'hDEADBEEF);

    // 3: same-address dual write, then non-conflicting dual write
    w0_en = 1'b1; w0_addr = 4'd5; w0_data = 32'h11;
    w1_en = 1'b1; w1_addr = 4'd5; w1_data = 32'h22;
    tick();
    check("conflict_set", {31'b0, wr_conflict}, 32'h1);
    idle();
    set_rd(2'b01, 4'd5, 4'd0);
    tick();
    check("conflict_clear", {31'b0, wr_conflict}, 32'h0);
    check("conflict_r5", port(0), 32'h22);
    idle();
    w0_en = 1'b1; w0_addr = 4'd6; w0_data = 32'h66;
    w1_en = 1'b1; w1_addr = 4'd8; w1_data = 32'h88;
    tick();
    check("noconflict", {31'b0, wr_conflict}, 32'h0);
    idle();
    set_rd(2'b11, 4'd6, 4'd8);
    tick();
    check("dual_r6", port(0), 32'h66);
    check("dual_r8", port(1), 32'h88);
    idle();

    // 4: same-cycle write and read of r7
    w0_en = 1'b1; w0_addr = 4'd7; w0_data = 32'hABCD;
    set_rd(2'b01, 4'd7, 4'd0);
    tick();
    check("same_cyc_r7", port(0), BYP ? 32'hABCD : 32'h0);
    w0_en = 1'b1; w0_addr = 4'd7; w0_data = 32'h1111;
    w1_en = 1'b1; w1_addr = 4'd7; w1_data = 32'h2222;
    set_rd(2'b10, 4'd0, 4'd7);
    tick();
    check("same_cyc_prio", port(1), BYP ? 32'h2222 : 32'hABCD);
    idle();
    set_rd(2'b11, 4'd7, 4'd7);
    tick();
    check("r7_final_p0", port(0), 32'h2222);
    check("r7_final_p1", port(1), 32'h2222);
    idle();

    // 5: scoreboard
    iss_en = 1'b1; iss_addr = 4'd9;
    set_rd(2'b00, 4'd9, 4'd10);
    #1;
    check("busy_pre_iss", {31'b0, rd_busy[0]}, 32'h0);
    tick();
    iss_en = 1'b0;
    #1;
    check("busy_after_iss", {31'b0, rd_busy[0]}, 32'h1);
    w1_en = 1'b1; w1_addr = 4'd9; w1_data = 32'h99;
    iss_en = 1'b1; iss_addr = 4'd9;
    #1;
    check("busy_iss_wr_same", {31'b0, rd_busy[0]}, 32'h1);
    tick();
    idle();
    #1;
    check("busy_set_wins", {31'b0, rd_busy[0]}, 32'h1);
    w0_en = 1'b1; w0_addr = 4'd9; w0_data = 32'h9A;
    #1;
    check("busy_wr_same_cyc", {31'b0, rd_busy[0]}, BYP ? 32'h0 : 32'h1);
    tick();
    idle();
    #1;
    check("busy_cleared", {31'b0, rd_busy[0]}, 32'h0);
    w0_en = 1'b1; w0_addr = 4'd10; w0_data = 32'hA0;
    tick();
    idle();
    #1;
    check("busy_nonbusy_wr", {31'b0, rd_busy[1]}, 32'h0);

    // 6: reset mid-stream
    iss_en = 1'b1; iss_addr = 4'd2;
    set_rd(2'b01, 4'd3, 4'd0);
    tick();
    idle();
    check("pre_rst_rd", port(0), 32'hDEADBEEF);
    set_rd(2'b00, 4'd2, 4'd2);
    #1;
    check("pre_rst_busy", {30'b0, rd_busy}, 32'h3);
    w0_en = 1'b1; w0_addr = 4'd2; w0_data = 32'h5555;
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_busy", {30'b0, rd_busy}, 32'h0);
    check("midrst_rd0", port(0), 32'h0);
    tick();
    idle();
    reset_n = 1'b1;
    set_rd(2'b11, 4'd2, 4'd14);
    tick();
    check("post_rst_r2", port(0), 32'h0);
    check("post_rst_r14", port(1), 32'h1000);
    check("post_rst_busy", {30'b0, rd_busy}, 32'h0);
    set_rd(2'b01, 4'd3, 4'd14);
    tick();
    check("post_rst_r3", port(0), 32'h0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
